// File: rtl/mem_dma_if.sv
// RAM initiator port of the block-copy engine: address, write strobe/data, read strobe, registered read data.
// No latency of its own; read data returns one cycle after ram_rEn, set by the RAM.
// No backpressure: the RAM accepts one access every cycle.
interface mem_dma_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wEn;
    logic [DATA_W-1:0] ram_wDat;
    logic              ram_rEn;
    logic [DATA_W-1:0] ram_rDat;

    modport master (
        output ram_addr,
        output ram_wEn,
        output ram_wDat,
        output ram_rEn,
        input  ram_rDat
    );

    modport slave (
        input  ram_addr,
        input  ram_wEn,
        input  ram_wDat,
        input  ram_rEn,
        output ram_rDat
    );
endinterface

// File: rtl/mem_dma.sv
// Block copy (or, with MEM_DMA_FILL_EN, block fill) of len words from src to dst through a single RAM port.
// Latency: done in cycle E0+2*len+1 for a copy, E0+len+1 for a fill, E0+1 when len=0.
// No backpressure: start is honoured only in IDLE and ignored otherwise; the RAM never stalls.
module mem_dma #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count,
    mem_dma_if.master         ram
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count_q;
    logic              last_word;
    logic              fill_mode;
    logic [DATA_W-1:0] fill_dat;

`ifdef MEM_DMA_FILL_EN
    logic              fill_q;
    logic [DATA_W-1:0] fill_val_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (state_q == IDLE && start) begin
            fill_q     <= fill;
            fill_val_q <= fill_val;
        end
    end

    assign fill_mode = fill_q;
    assign fill_dat  = fill_val_q;
`else
    logic unused_fill;
    assign unused_fill = ^{fill, fill_val};
    assign fill_mode   = 1'b0;
    assign fill_dat    = '0;
`endif

    assign last_word = (count_q + LEN_W'(1)) == len_q;
    assign count     = count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
`ifdef MEM_DMA_FILL_EN
                        state_d = fill ? WR : RD;
`else
                        state_d = RD;
`endif
                    end
                end
            end
            RD:      state_d = WR;
            WR:      state_d = last_word ? DONE : (fill_mode ? WR : RD);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are frozen for the whole transfer; count advances once per written word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
        end else if (state_q == IDLE && start) begin
            src_q   <= src;
            dst_q   <= dst;
            len_q   <= len;
            count_q <= '0;
        end else if (state_q == WR) begin
            count_q <= count_q + LEN_W'(1);
        end
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        ram.ram_addr = '0;
        ram.ram_wEn  = 1'b0;
        ram.ram_wDat = '0;
        ram.ram_rEn  = 1'b0;
        case (state_q)
            RD: begin
                busy         = 1'b1;
                ram.ram_rEn  = 1'b1;
                ram.ram_addr = src_q + ADDR_W'(count_q);
            end
            WR: begin
                busy         = 1'b1;
                ram.ram_wEn  = 1'b1;
                ram.ram_addr = dst_q + ADDR_W'(count_q);
                ram.ram_wDat = fill_mode ? fill_dat : ram.ram_rDat;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Randomised and directed bench for mem_dma against a word-array reference model with a write/read/done scoreboard.
module tb_mem_dma;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int LW    = 10;
    localparam int DEPTH = 512;

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b1;
    logic          start    = 1'b0;
    logic          fill     = 1'b0;
    logic [AW-1:0] src      = '0;
    logic [AW-1:0] dst      = '0;
    logic [LW-1:0] len      = '0;
    logic [DW-1:0] fill_val = '0;
    logic          busy;
    logic          done;
    logic [LW-1:0] count;

    mem_dma_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_dma #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill     (fill),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .ram      (bus)
    );

    always #5 clock = ~clock;

    // RAM model with a side port used only for preloading.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdat;
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_dat  = '0;

    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_dat;
        else if (bus.ram_wEn) mem[bus.ram_addr] <= bus.ram_wDat;
        if (bus.ram_rEn) rdat <= mem[bus.ram_addr];
    end
    assign bus.ram_rDat = rdat;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int s; int d; int cnt; } op_t;

    logic [DW-1:0] ref_mem [DEPTH];
    wr_t           wq [$];
    logic [AW-1:0] rq [$];
    op_t           oq [$];
    int            nc     = 0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin : mon
        bit  bexp;
        wr_t w;
        op_t op;
        nc++;
        if (pl_en) ref_mem[pl_addr] = pl_dat;
        if (reset_n) begin
            bexp = (oq.size() > 0) && (nc > oq[0].s) && (nc < oq[0].d);
            chk("busy", busy, bexp);
            chk("en_excl", bus.ram_rEn & bus.ram_wEn, 0);
            if (!bexp) begin
                chk("idle_ren", bus.ram_rEn, 0);
                chk("idle_wen", bus.ram_wEn, 0);
                chk("idle_addr", bus.ram_addr, 0);
            end
            if (bus.ram_rEn) begin
                if (rq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected actual=%0d required=none", bus.ram_addr);
                end else chk("rd_addr", bus.ram_addr, rq.pop_front());
            end
            if (bus.ram_wEn) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected actual=%0d required=none", bus.ram_addr);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", bus.ram_addr, w.addr);
                    chk("wr_data", bus.ram_wDat, w.data);
                    ref_mem[w.addr] = w.data;
                end
            end
            if (done) begin
                if (oq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected actual=1 required=0 cycle=%0d", nc);
                end else begin
                    op = oq.pop_front();
                    chk("done_cycle", nc, op.d);
                    chk("done_count", count, op.cnt);
                    chk("wr_left", wq.size(), 0);
                    chk("rd_left", rq.size(), 0);
                end
            end
        end
    end

    task automatic poke(input int a, input logic [DW-1:0] v);
        @(negedge clock); #1;
        pl_en = 1'b1; pl_addr = AW'(a); pl_dat = v;
    endtask

    task automatic poke_end();
        @(negedge clock); #1;
        pl_en = 1'b0;
    endtask

    // Expected writes come from replaying the copy word by word on a snapshot of the model memory.
    task automatic issue(input int s, input int d, input int l, input bit f, input logic [DW-1:0] fv);
        logic [DW-1:0] tmp [DEPTH];
        op_t op;
        wr_t w;
        bit  fm;
        fm = 1'b0;
`ifdef MEM_DMA_FILL_EN
        fm = f;
`endif
        @(negedge clock); #1;
        tmp = ref_mem;
        for (int k = 0; k < l; k++) begin
            w.addr = AW'(d + k);
            if (fm) w.data = fv;
            else begin
                rq.push_back(AW'(s + k));
                w.data = tmp[AW'(s + k)];
            end
            tmp[w.addr] = w.data;
            wq.push_back(w);
        end
        op.s   = nc;
        op.d   = (l == 0) ? nc + 1 : (fm ? nc + l + 1 : nc + 2 * l + 1);
        op.cnt = l;
        oq.push_back(op);
        start = 1'b1; src = AW'(s); dst = AW'(d); len = LW'(l); fill = f; fill_val = fv;
        @(negedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (oq.size() != 0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (oq.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout actual=%0d required=0 pending ops", oq.size());
            oq.delete(); wq.delete(); rq.delete();
        end
        @(negedge clock);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_addr"}, bus.ram_addr, 0);
        chk({tag, "_wen"}, bus.ram_wEn, 0);
        chk({tag, "_ren"}, bus.ram_rEn, 0);
        chk({tag, "_wdat"}, bus.ram_wDat, 0);
    endtask

    logic [DW-1:0] pre [4];

    initial begin
        #1 reset_n = 1'b0;
        #1 check_outputs_zero("reset");
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
        for (int i = 0; i < 4; i++) poke(i, 32'hA0 + i);
        poke(10, 1); poke(11, 2); poke(12, 3);
        poke_end();
        @(negedge clock); #1 reset_n = 1'b1;
        @(negedge clock);

        issue(0, 100, 4, 0, 0);
        wait_idle();
        for (int i = 0; i < 4; i++) chk("copy_mem", mem[100 + i], 32'hA0 + i);
        chk("copy_count_hold", count, 4);

        pre[0] = mem[510]; pre[1] = mem[511]; pre[2] = mem[0]; pre[3] = mem[1];
        issue(510, 5, 4, 0, 0);
        wait_idle();
        for (int i = 0; i < 4; i++) chk("wrap_src", mem[5 + i], pre[i]);

        pre[0] = mem[0]; pre[1] = mem[1]; pre[2] = mem[2];
        issue(0, 510, 3, 0, 0);
        wait_idle();
        chk("wrap_dst0", mem[510], pre[0]);
        chk("wrap_dst1", mem[511], pre[1]);
        chk("wrap_dst2", mem[0], pre[2]);

        issue(33, 44, 0, 0, 0);
        wait_idle();

        // Stray start mid-copy must not disturb the transfer or queue a second one.
        issue(60, 260, 8, 0, 0);
        repeat (3) @(negedge clock);
        #1 start = 1'b1; src = 9'd300; dst = 9'd400; len = 10'd7;
        @(negedge clock); #1 start = 1'b0;
        wait_idle();

        issue(10, 11, 2, 0, 0);
        wait_idle();
        chk("overlap11", mem[11], 1);
        chk("overlap12", mem[12], 1);

        for (int i = 0; i < 3; i++) pre[i] = mem[200 + i];
        issue(200, 20, 3, 1, 32'hDEADBEEF);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
`ifdef MEM_DMA_FILL_EN
            chk("fill_mem", mem[20 + i], 32'hDEADBEEF);
`else
            chk("fill_as_copy", mem[20 + i], pre[i]);
`endif
        end

        issue(7, 300, 512, 0, 0);
        wait_idle();

        for (int r = 0; r < 25; r++) begin
            issue($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, 40), 1'($urandom_range(0, 1)), $urandom);
            wait_idle();
        end

        // Abort mid-copy: outputs clear in the same cycle, already-written words stay.
        issue(40, 150, 20, 0, 0);
        repeat (7) @(negedge clock);
        @(posedge clock); #1 reset_n = 1'b0;
        #1 check_outputs_zero("abort");
        oq.delete(); wq.delete(); rq.delete();
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clock);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        issue(90, 400, 5, 0, 0);
        wait_idle();

        for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
